e1_p2s_buf: RTL and testbench

- Parallel-to-serial stage for the E1 datapath. Consumes the full bundle produced by the E1 serial-to-parallel collector or the compute stage: SEQ_CNT words of APP_DATA_WIDTH.
- Emits the bundle one word per cycle on a valid/ready stream toward the application write interface.
- Holds a DEPTH-entry bundle FIFO so the upstream stage can deliver back-to-back bundles while the output drains.
- Word ordering is the inverse of the collector, so a collector→buffer round trip returns words in their original order.

---
 rtl/e1_p2s_buf.sv | 116 +++++++++++
 tb/tb_e1_p2s_buf.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/e1_p2s_buf.sv
// E1 parallel-to-serial buffer: queues whole bundles in a small FIFO and
// streams each bundle out one word per cycle, word 0 first.
module e1_p2s_buf #(
  parameter int SEQ_CNT        = 5,
  parameter int APP_DATA_WIDTH = 64,
  parameter int DEPTH          = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [APP_DATA_WIDTH*SEQ_CNT-1:0] par_in,
  input  logic                              par_in_valid,
  output logic                              par_in_ready,
  output logic [APP_DATA_WIDTH-1:0]         seq_out,
  output logic                              seq_out_valid,
  input  logic                              seq_out_ready,
  output logic                              seq_last,
  output logic                              busy
);

  localparam int BUS_W = APP_DATA_WIDTH * SEQ_CNT;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (SEQ_CNT > 1) ? $clog2(SEQ_CNT) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SEQ_CNT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  logic [BUS_W-1:0]          mem_r [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_r;
  logic [PTR_W-1:0]          rd_ptr_r;
  logic [CNT_W-1:0]          count_r;
  logic [IDX_W-1:0]          idx_r;

  logic [BUS_W-1:0]          head_s;
  logic [APP_DATA_WIDTH-1:0] word_s;
  logic                      not_empty_s;
  logic                      push_s;
  logic                      word_hs_s;
  logic                      pop_s;

  // Handshake decode; ready ignores same-cycle pops so no path from seq_out_ready.
  always_comb begin
    not_empty_s  = (count_r != CNT_ZERO);
    par_in_ready = !rst && (count_r < FULL_CNT);
    push_s       = par_in_valid && par_in_ready;
    word_hs_s    = not_empty_s && seq_out_ready;
    pop_s        = word_hs_s && (idx_r == LAST_IDX);
  end

  // Bundle storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= par_in;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Word index within the head bundle; wraps to 0 as the bundle pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= {IDX_W{1'b0}};
    end else if (word_hs_s) begin
      if (idx_r == LAST_IDX) begin
        idx_r <= {IDX_W{1'b0}};
      end else begin
        idx_r <= idx_r + IDX_ONE;
      end
    end
  end

  // Head-word select: word i sits at bits [(i+1)*W-1 : i*W] of the bundle.
  always_comb begin
    head_s = mem_r[rd_ptr_r];
    word_s = {APP_DATA_WIDTH{1'b0}};
    for (int i = 0; i < SEQ_CNT; i++) begin
      if (idx_r == IDX_W'(i)) begin
        word_s = head_s[i*APP_DATA_WIDTH +: APP_DATA_WIDTH];
      end else begin
        word_s = word_s;
      end
    end
  end

  // Output stream; all terms come from registered state so they hold under stall.
  always_comb begin
    seq_out       = word_s;
    seq_out_valid = not_empty_s;
    seq_last      = not_empty_s && (idx_r == LAST_IDX);
    busy          = not_empty_s;
  end

endmodule

// File: tb/tb_e1_p2s_buf.sv
// Randomised and directed bench for e1_p2s_buf against a queue-based model.
module tb_e1_p2s_buf;

  localparam int SEQ_CNT = 5;
  localparam int W       = 64;
  localparam int DEPTH   = 2;
  localparam int BUS_W   = W * SEQ_CNT;

  logic             clk;
  logic             rst;
  logic [BUS_W-1:0] par_in;
  logic             par_in_valid;
  logic             par_in_ready;
  logic [W-1:0]     seq_out;
  logic             seq_out_valid;
  logic             seq_out_ready;
  logic             seq_last;
  logic             busy;

  int n_cmp;
  int n_err;

  // Reference model: queue of stored bundles and words already emitted from the head.
  logic [BUS_W-1:0] model_q[$];
  int               model_pos;

  e1_p2s_buf #(.SEQ_CNT(SEQ_CNT), .APP_DATA_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .par_in(par_in), .par_in_valid(par_in_valid), .par_in_ready(par_in_ready),
    .seq_out(seq_out), .seq_out_valid(seq_out_valid), .seq_out_ready(seq_out_ready),
    .seq_last(seq_last), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] word_of(input logic [BUS_W-1:0] b, input int k);
    return b[k*W +: W];
  endfunction

  function automatic logic [BUS_W-1:0] make_bundle(input logic [W-1:0] base);
    logic [BUS_W-1:0] b;
    for (int i = 0; i < SEQ_CNT; i++) b[i*W +: W] = base + W'(i);
    return b;
  endfunction

  function automatic logic [BUS_W-1:0] rand_bundle();
    logic [BUS_W-1:0] b;
    for (int i = 0; i < SEQ_CNT; i++) b[i*W +: W] = {$urandom(), $urandom()};
    return b;
  endfunction

  // One cycle: check outputs against the model, drive new inputs, advance the model.
  task automatic step(input logic v, input logic [BUS_W-1:0] d, input logic ordy,
                      input logic r, output logic accepted);
    logic exp_valid;
    logic hs;
    @(negedge clk);
    exp_valid = (model_q.size() > 0);
    chk("valid", 64'(seq_out_valid), 64'(exp_valid));
    chk("busy", 64'(busy), 64'(exp_valid));
    chk("last", 64'(seq_last), 64'(exp_valid && model_pos == SEQ_CNT - 1));
    chk("in_ready", 64'(par_in_ready), 64'(!rst && model_q.size() < DEPTH));
    if (exp_valid) chk("seq_out", 64'(seq_out), 64'(word_of(model_q[0], model_pos)));
    rst           = r;
    par_in_valid  = v;
    par_in        = d;
    seq_out_ready = ordy;
    accepted = v && !r && (model_q.size() < DEPTH);
    hs       = !r && exp_valid && ordy;
    @(posedge clk);
    if (r) begin
      model_q.delete();
      model_pos = 0;
    end else begin
      if (hs) begin
        if (model_pos == SEQ_CNT - 1) begin
          void'(model_q.pop_front());
          model_pos = 0;
        end else begin
          model_pos++;
        end
      end
      if (accepted) model_q.push_back(d);
    end
  endtask

  logic             acc;
  logic [BUS_W-1:0] bun;
  int               nvalid, nlast, first_v, last_v, guard, pending;

  initial begin
    n_cmp = 0; n_err = 0; model_pos = 0;
    rst = 1'b1; par_in_valid = 1'b0; par_in = '0; seq_out_ready = 1'b0;

    // Reset.
    step(1'b0, '0, 1'b0, 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b1, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);

    // Single bundle, words 100..104, ready held high.
    step(1'b1, make_bundle(64'h100), 1'b1, 1'b0, acc);
    chk("single_acc", 64'(acc), 64'd1);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0, acc);

    // Backpressure: ready pattern 1,0,0,1,0,0,...
    step(1'b1, make_bundle(64'h200), 1'b0, 1'b0, acc);
    for (int i = 0; i < 18; i++) step(1'b0, '0, (i % 3) == 0, 1'b0, acc);

    // Full FIFO: A and B stored, C held until A drains.
    step(1'b1, make_bundle(64'hA00), 1'b0, 1'b0, acc);
    step(1'b1, make_bundle(64'hB00), 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, make_bundle(64'hC00), 1'b0, 1'b0, acc);
      chk("full_c_held", 64'(acc), 64'd0);
    end
    guard = 0;
    acc = 1'b0;
    while (!acc && guard < 20) begin
      step(1'b1, make_bundle(64'hC00), 1'b1, 1'b0, acc);
      guard++;
    end
    chk("full_c_after_a", 64'(guard), 64'd6);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b0, acc);

    // Back-to-back: four bundles, upstream valid whenever it has one.
    pending = 4; nvalid = 0; nlast = 0; first_v = -1; last_v = -1;
    bun = rand_bundle();
    for (int i = 0; i < 26; i++) begin
      step(pending > 0, bun, 1'b1, 1'b0, acc);
      if (seq_out_valid) begin
        nvalid++;
        if (first_v < 0) first_v = i;
        last_v = i;
      end
      if (seq_last) nlast++;
      if (acc) begin
        pending--;
        bun = rand_bundle();
      end
    end
    chk("b2b_words", 64'(nvalid), 64'd20);
    chk("b2b_no_gap", 64'(last_v - first_v + 1), 64'd20);
    chk("b2b_lasts", 64'(nlast), 64'd4);

    // Simultaneous push and pop on the last word of the head bundle.
    step(1'b1, make_bundle(64'h300), 1'b1, 1'b0, acc);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, acc);
    step(1'b1, make_bundle(64'h400), 1'b1, 1'b0, acc);
    chk("simul_acc", 64'(acc), 64'd1);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    chk("simul_word0", 64'(seq_out), 64'h400);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0, acc);

    // Reset mid-bundle with a second bundle queued.
    step(1'b1, make_bundle(64'h500), 1'b0, 1'b0, acc);
    step(1'b1, make_bundle(64'h600), 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b1, acc);
    chk("rst_ready_low", 64'(par_in_ready), 64'd0);
    step(1'b1, make_bundle(64'h700), 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    chk("rst_new_word0", 64'(seq_out), 64'h700);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0, acc);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_bundle(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 199) == 0, acc);
    end
    step(1'b0, '0, 1'b1, 1'b0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
